// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Deframes the registered serial bit stream coming out of the upstream input
// flip-flop into parallel words.
//
// Frame format on the line (one bit per bit_en strobe, line idles high):
//   start(0), DATA_W data bits LSB first, optional parity bit, stop(1).
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   din        - serial bit from the upstream flop's Q
//   bit_en     - sample strobe; din only matters on cycles where it is 1
//   data_out   - last received word (held until the next data_valid)
//   data_valid - one-cycle pulse when data_out/parity_err/frame_err update
//   parity_err - last frame's parity bit did not match
//   frame_err  - last frame's stop bit was sampled as 0
//   busy       - receiver is inside a frame (any state but IDLE)
//   err_count  - saturating count of frames that had any error

module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_shift;
  logic              r_parityBit;
  logic [DATA_W-1:0] r_dataOut;
  logic              r_dataValid;
  logic              r_parityErr;
  logic              r_frameErr;
  logic [7:0]        r_errCount;

  logic              w_expParity;
  logic              w_parityErr;
  logic              w_frameErr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; the FSM only ever moves on a strobe. Leaving STOP always
  // goes to IDLE, so a 0 stop bit is never reused as the next start bit.
  always_comb begin
    w_nextState = r_state;
    if (bit_en) begin
      case (r_state)
        IDLE:    if (!din) w_nextState = DATA;
        DATA:    if (r_count == LAST_IDX) w_nextState = PARITY_EN ? PARITY : STOP;
        PARITY:  w_nextState = STOP;
        STOP:    w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Frame checks evaluated during the stop-bit strobe, when the word is complete.
  assign w_expParity = (^r_shift) ^ ODD_PARITY;
  assign w_parityErr = PARITY_EN & (r_parityBit != w_expParity);
  assign w_frameErr  = ~din;

  // Datapath: bit capture while inside a frame, and the result registers that
  // update together with the data_valid pulse on the stop-bit strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_shift     <= '0;
      r_parityBit <= 1'b0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_errCount  <= 8'd0;
    end else begin
      r_dataValid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          IDLE: begin
            r_count <= '0;
          end
          DATA: begin
            r_shift[r_count] <= din;
            r_count          <= r_count + CNT_W'(1);
          end
          PARITY: begin
            r_parityBit <= din;
          end
          STOP: begin
            r_dataOut   <= r_shift;
            r_dataValid <= 1'b1;
            r_parityErr <= w_parityErr;
            r_frameErr  <= w_frameErr;
            if ((w_parityErr || w_frameErr) && (r_errCount != 8'hFF)) begin
              r_errCount <= r_errCount + 8'd1;
            end
          end
          default: begin
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign data_out   = r_dataOut;
  assign data_valid = r_dataValid;
  assign parity_err = r_parityErr;
  assign frame_err  = r_frameErr;
  assign err_count  = r_errCount;
  assign busy       = (r_state != IDLE);

endmodule
